// File: rtl/data_memory_lsu.sv
// Byte-addressable RV32 data memory with load/store lane handling and a
// single-outstanding request/response handshake (one access every two cycles).
module data_memory_lsu #(
  parameter int unsigned MEM_SIZE  = 4096,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_req,
  input  logic                        i_we,
  input  logic [2:0]                  i_funct3,
  input  logic [$clog2(MEM_SIZE)-1:0] i_addr,
  input  logic [31:0]                 i_wdata,
  output logic                        o_ready,
  output logic                        o_rvalid,
  output logic [31:0]                 o_rdata,
  output logic                        o_err
);

  localparam int unsigned AW    = $clog2(MEM_SIZE);
  localparam int unsigned WORDS = MEM_SIZE / 4;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] FILL  = INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Contents survive reset; the declaration value only sets the power-up image.
  logic [31:0] mem [WORDS] = '{default: FILL};

  logic [IW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_val;
  logic [31:0]   wword;
  logic [3:0]    be;
  logic          legal;
  logic          aligned;
  logic          access_ok;
  logic          accept;
  logic          do_write;

  generate
    if (AW > 2) begin : g_widx
      assign widx = IW'(i_addr[AW-1:2]);
    end else begin : g_widx_single
      assign widx = '0;
    end
  endgenerate

  assign lane     = i_addr[1:0];
  assign rd_word  = mem[widx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  // Legality, alignment, lane enables and load extraction for the presented request.
  always_comb begin
    legal    = 1'b0;
    aligned  = 1'b0;
    be       = 4'b0000;
    wword    = 32'h0;
    load_val = 32'h0;

    if (i_we) begin
      legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
    end else begin
      legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
              (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
    end

    case (i_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~i_addr[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b0;
    endcase

    case (i_funct3[1:0])
      2'b00: begin
        be    = 4'(4'b0001 << lane);
        wword = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        be    = i_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{i_wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wword = i_wdata;
      end
      default: begin
        be    = 4'b0000;
        wword = 32'h0;
      end
    endcase

    case (i_funct3)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'h0, rd_shift[7:0]};
      3'b101:  load_val = {16'h0, rd_shift[15:0]};
      default: load_val = 32'h0;
    endcase
  end

  assign access_ok = legal && aligned;
  // Requests are only taken in IDLE and never while reset is asserted.
  assign accept    = i_rst_n && (state_q == IDLE) && i_req;
  assign do_write  = accept && i_we && access_ok;

  // Next-state and registered response contents.
  always_comb begin
    state_d = state_q;
    rdata_d = 32'h0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          state_d = RESP;
          err_d   = ~access_ok;
          rdata_d = (!i_we && access_ok) ? load_val : 32'h0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane write port.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[widx][8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_rvalid = (state_q == RESP);
  assign o_rdata  = rdata_q;
  assign o_err    = err_q;

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
Byte-addressable RV32IM data memory with RISC-V load/store semantics.
- Supports byte, halfword and word stores through byte-lane writes.
- Loads return sign- or zero-extended data.
- Illegal and misaligned accesses are detected and signalled.
- A request/response handshake with one-cycle registered response decouples the memory from the core's MEM stage.

Parameters:
- MEM_SIZE, 4096: memory size in bytes. Must be a power of two and at least 4. Organised as MEM_SIZE/4 words of 32 bits.
- INIT_ZERO, 1: when 1, all memory words are set to 0 at simulation start. Reset never clears memory contents.

Ports:
- i_clk, input, 1: clock. All state changes on the rising edge.
- i_rst_n, input, 1: reset, synchronous, active-low.
- i_req, input, 1: access request.
- i_we, input, 1: 1 = store, 0 = load.
- i_funct3, input, 3: RISC-V access size and sign code.
- i_addr, input, $clog2(MEM_SIZE): byte address.
- i_wdata, input, 32: store data. Low bits are used for SB/SH.
- o_ready, output, 1: request can be accepted this cycle.
- o_rvalid, output, 1: response valid. Pulses for exactly 1 cycle per accepted request.
- o_rdata, output, 32: load result. 0 for stores and errors.
- o_err, output, 1: accepted request was illegal or misaligned. Valid only with o_rvalid.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - state goes to IDLE.
  - o_rvalid=0, o_rdata=0, o_err=0.
  - o_ready=1 on the cycle after reset is released.
  - Memory contents are preserved.
  - A response pending at reset is dropped and never presented.
- FSM has two states:
  - IDLE: o_ready=1. If i_req=1 the request is accepted: perform the access, register the response, go to RESP.
  - RESP: o_ready=0, o_rvalid=1 with o_rdata and o_err. On the next edge return to IDLE and set o_rvalid=0. i_req in RESP is ignored and produces no side effect.
- Throughput: one access per 2 cycles. Latency: response appears the cycle after acceptance.
- Word index is i_addr[MSB:2]; byte lane is i_addr[1:0].
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code, including 100/101 with i_we=1, is illegal. Illegal accesses give o_err=1, no write, o_rdata=0.
- Alignment rules:
  - Halfword access requires i_addr[0]=0.
  - Word access requires i_addr[1:0]=0.
  - A misaligned access gives o_err=1, no memory update, o_rdata=0.
- Stores update only the addressed lanes at the accept edge:
  - SB writes lane i_addr[1:0] with i_wdata[7:0].
  - SH writes lanes {i_addr[1],0} and {i_addr[1],1} with i_wdata[15:0], little-endian.
  - SW writes all 4 lanes.
  - Unaddressed lanes are unchanged.
- Loads read the word at the accept edge, extract the addressed byte/halfword little-endian, then extend:
  - LB/LH sign-extend to 32 bits.
  - LBU/LHU zero-extend to 32 bits.
- Store response: o_rvalid=1, o_rdata=0, o_err per legality.
- A store followed by a load to the same address returns the new data; the store's accept edge always precedes the load's accept edge.
- Address wrap-around cannot occur: i_addr width exactly spans MEM_SIZE.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> o_rvalid for 1 cycle one cycle after acceptance, o_rdata=0xDEADBEEF, o_err=0.
- With 0xDEADBEEF @0x10:
  - LB @0x13 -> 0xFFFFFFDE.
  - LBU @0x13 -> 0x000000DE.
  - LH @0x12 -> 0xFFFFDEAD.
  - LHU @0x10 -> 0x0000BEEF.
- SB 0x5A @0x11, then SH 0x1234 @0x12, then LW @0x10 -> 0x12345AEF (lanes merged, untouched lane 0 kept).
- Illegal and misaligned accesses:
  - SH @0x21 -> o_err=1; LW @0x20 is unchanged (still 0).
  - LW @0x22 -> o_err=1, o_rdata=0.
  - funct3=011 load -> o_err=1.
  - funct3=100 with i_we=1 -> o_err=1, no write.
- Back-to-back handshake: i_req held high for 4 cycles with stores to 0x0, 0x4, 0x8, 0xC -> only 2 accepted (cycles 0 and 2), o_ready pattern 1,0,1,0, 2 o_rvalid pulses.
- Reset:
  - Assert i_rst_n=0 in the RESP cycle of a LW -> no o_rvalid pulse after reset, all outputs 0.
  - A previously written word is still readable after reset.
